div_sequencer: RTL and testbench

- Multi-cycle 8-bit divider controller for the ALU arithmetic unit.
- Sequences one instance of the team's `subtractor` (A, B -> Diff, Borrow) through a restoring-division algorithm, producing one quotient bit per clock.
- Supports unsigned and signed (two's-complement, truncating toward zero) division with a start/done handshake.
- Sits beside the adder/subtractor in the arithmetic unit and is selected by the ALU opcode decoder for DIV/MOD operations.

---
 rtl/div_sequencer.sv | 165 ++++++++++++++++
 tb/tb_div_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle 8-bit restoring divider controller that produces one quotient bit per clock.
// Supports unsigned and signed (truncating) division through one shared subtractor.
module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);
    assign {Borrow, Diff} = {1'b0, A} - {1'b0, B};
endmodule

module div_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] r_q, r_d, qsh_q, qsh_d, bmag_q, bmag_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] s, diff;
    logic             c, borrow, qbit;

    assign c    = r_q[WIDTH-1];
    assign s    = {r_q[WIDTH-2:0], qsh_q[WIDTH-1]};
    assign qbit = c | ~borrow;

    subtractor #(.WIDTH(WIDTH)) u_sub (
        .A      (s),
        .B      (bmag_q),
        .Diff   (diff),
        .Borrow (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            qsh_q   <= '0;
            bmag_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            qsh_q   <= qsh_d;
            bmag_q  <= bmag_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        qsh_d   = qsh_q;
        bmag_d  = bmag_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = signed_mode;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                qsh_d  = (mode_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                bmag_d = (mode_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                qneg_d = mode_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                rneg_d = mode_q & dvd_q[WIDTH-1];
                r_d    = '0;
                cnt_d  = '0;
                // Zero divisor publishes results now but still passes through FIX
                // so done lands two edges after acceptance.
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b1;
                    state_d = FIX;
                end else begin
                    dz_d    = 1'b0;
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d   = qbit ? diff : s;
                qsh_d = {qsh_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = FIX;
            end
            FIX: begin
                if (!dz_q) begin
                    quo_d = qneg_q ? -qsh_q : qsh_q;
                    rem_d = rneg_q ? -r_q : r_q;
                    ovf_d = mode_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
        done        = (state_q == DONE);
        quotient    = quo_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero, overflow;
    logic [7:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] prev_q = 8'h00;
    logic [7:0] prev_r = 8'h00;

    div_sequencer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; latency counts edges after the sampling edge.
    task automatic do_div(input string tag, input logic m, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov);
        int lat;
        lat = 0;
        @(negedge clk);
        signed_mode = m; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = ~a; divisor = 8'h5A; signed_mode = ~m;
        check({tag, "_busy_on"}, 16'(busy), 16'd1);
        check({tag, "_held_q"}, 16'(quotient), 16'(prev_q));
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            if (n == 5) check({tag, "_busy_mid"}, 16'(busy), 16'd1);
        end
        check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
        check({tag, "_busy_done"}, 16'(busy), 16'd0);
        check({tag, "_quot"}, 16'(quotient), 16'(eq));
        check({tag, "_rem"}, 16'(remainder), 16'(er));
        check({tag, "_dbz"}, 16'(div_by_zero), 16'(edz));
        check({tag, "_ovf"}, 16'(overflow), 16'(eov));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 16'(done), 16'd0);
        check({tag, "_quot_hold"}, 16'(quotient), 16'(eq));
        prev_q = eq; prev_r = er;
    endtask

    initial begin
        int ndone, first;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_outs", {quotient, remainder}, 16'h0000);
        check("rst_flags", {14'd0, div_by_zero, overflow}, 16'd0);
        @(negedge clk); rst_n = 1'b1;

        do_div("u200_7",   1'b0, 8'd200, 8'd7,   10, 8'h1C, 8'h04, 1'b0, 1'b0);
        do_div("s-100_7",  1'b1, 8'h9C,  8'h07,  10, 8'hF2, 8'hFE, 1'b0, 1'b0);
        do_div("s100_-7",  1'b1, 8'h64,  8'hF9,  10, 8'hF2, 8'h02, 1'b0, 1'b0);
        do_div("u255_200", 1'b0, 8'd255, 8'd200, 10, 8'h01, 8'h37, 1'b0, 1'b0);
        do_div("u200_129", 1'b0, 8'd200, 8'd129, 10, 8'h01, 8'h47, 1'b0, 1'b0);
        do_div("u255_1",   1'b0, 8'd255, 8'd1,   10, 8'hFF, 8'h00, 1'b0, 1'b0);
        do_div("u2A_0",    1'b0, 8'h2A,  8'h00,  2,  8'hFF, 8'h2A, 1'b1, 1'b0);
        do_div("s80_FF",   1'b1, 8'h80,  8'hFF,  10, 8'h80, 8'h00, 1'b0, 1'b1);
        do_div("s80_01",   1'b1, 8'h80,  8'h01,  10, 8'h80, 8'h00, 1'b0, 1'b0);
        do_div("u80_FF",   1'b0, 8'h80,  8'hFF,  10, 8'h00, 8'h80, 1'b0, 1'b0);

        // Second start during ITER cycle 3 must be dropped.
        @(negedge clk);
        signed_mode = 1'b0; dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first == 0) first = n;
            end
        end
        check("ign_ndone", 16'(ndone), 16'd1);
        check("ign_latency", 16'(first), 16'd5);
        check("ign_quot", 16'(quotient), 16'd14);
        check("ign_rem", 16'(remainder), 16'd2);
        prev_q = 8'd14; prev_r = 8'd2;

        // Reset during ITER cycle 4 aborts with all outputs cleared at once.
        @(negedge clk);
        signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 16'(busy), 16'd0);
        check("arst_outs", {quotient, remainder}, 16'h0000);
        check("arst_flags", {14'd0, div_by_zero, overflow}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst_no_done", 16'(ndone), 16'd0);
        prev_q = 8'h00; prev_r = 8'h00;

        do_div("u9_3", 1'b0, 8'd9, 8'd3, 10, 8'h03, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
